// File: rtl/cbg_bank_responder_if.sv
// ---------------------------------------------------------------------------
// cbg_bank_responder_if
// Bundle of the LSU-side request/response signals between the PE-row LSUs
// and the bank responder.
//   R_request      : per-LSU read request (level)
//   W_request      : per-LSU write request (level)
//   LSU_addr_bus   : per-LSU word address, slice i at [i*ADDR_W +: ADDR_W]
//   LSU_wdata_bus  : per-LSU write data, slice i at [i*DATA_W +: DATA_W]
//   grant          : one-hot (or zero) grant back to the LSUs
//   CBG_to_LSU_bus : per-LSU return slice {rvalid, rdata}
// master = LSU side, slave = bank responder side.
// ---------------------------------------------------------------------------
interface cbg_bank_responder_if #(
  parameter int NUM_LSU = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  logic [NUM_LSU-1:0]            R_request;
  logic [NUM_LSU-1:0]            W_request;
  logic [NUM_LSU*ADDR_W-1:0]     LSU_addr_bus;
  logic [NUM_LSU*DATA_W-1:0]     LSU_wdata_bus;
  logic [NUM_LSU-1:0]            grant;
  logic [NUM_LSU*(DATA_W+1)-1:0] CBG_to_LSU_bus;

  modport master (
    output R_request, W_request, LSU_addr_bus, LSU_wdata_bus,
    input  grant, CBG_to_LSU_bus
  );

  modport slave (
    input  R_request, W_request, LSU_addr_bus, LSU_wdata_bus,
    output grant, CBG_to_LSU_bus
  );
endinterface

// File: rtl/cbg_bank_responder.sv
// ---------------------------------------------------------------------------
// cbg_bank_responder
// Memory-side responder for the LSU load/store protocol. Round-robin
// arbitrates NUM_LSU level requests onto one single-port data bank (one
// access per cycle), returns read data one cycle after the grant on the
// per-LSU return slice, and offers a host preload port with priority over
// all LSU traffic.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (clears pointer and return
//               registers, blocks grants and bank writes; bank not cleared)
//   init_en   : host preload write strobe
//   init_addr : host preload address
//   init_data : host preload data
//   lsu       : LSU request/response bundle (slave side)
// ---------------------------------------------------------------------------
module cbg_bank_responder #(
  parameter int NUM_LSU = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_en,
  input  logic [ADDR_W-1:0]    init_addr,
  input  logic [DATA_W-1:0]    init_data,
  cbg_bank_responder_if.slave  lsu
);

  localparam int PTR_W = (NUM_LSU > 1) ? $clog2(NUM_LSU) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  // Arbitration
  logic [NUM_LSU-1:0] req_s;
  logic [NUM_LSU-1:0] grant_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic               gnt_any_s;
  logic               hit_s;
  int                 probe_s;
  logic [PTR_W-1:0]   rr_next_s;
  logic [PTR_W-1:0]   rr_ptr_r;

  // Granted access
  logic               gnt_wr_s;
  logic               gnt_rd_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_wdata_s;
  logic [DATA_W-1:0]  rd_word_s;

  // Return path and bank
  logic [NUM_LSU-1:0] rvalid_r;
  logic [DATA_W-1:0]  rdata_r [NUM_LSU];
  logic [DATA_W-1:0]  mem [DEPTH];

  assign req_s = lsu.R_request | lsu.W_request;

  // Round-robin search starting at rr_ptr; preload and reset suppress grants.
  always_comb begin
    grant_s   = '0;
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    hit_s     = 1'b0;
    probe_s   = 0;
    for (int k = 0; k < NUM_LSU; k++) begin
      probe_s   = (int'(rr_ptr_r) + k) % NUM_LSU;
      // First requester found in the rotated order wins; later ones are masked.
      hit_s     = ~gnt_any_s & req_s[probe_s] & ~init_en & ~rst;
      grant_s[probe_s] = grant_s[probe_s] | hit_s;
      gnt_idx_s = hit_s ? PTR_W'(probe_s) : gnt_idx_s;
      gnt_any_s = gnt_any_s | hit_s;
    end
  end

  // Steer the granted LSU's address/data onto the bank (grant is one-hot).
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NUM_LSU; i++) begin
      sel_addr_s  = sel_addr_s  | ({ADDR_W{grant_s[i]}} & lsu.LSU_addr_bus[i*ADDR_W +: ADDR_W]);
      sel_wdata_s = sel_wdata_s | ({DATA_W{grant_s[i]}} & lsu.LSU_wdata_bus[i*DATA_W +: DATA_W]);
    end
  end

  // A write request takes the grant; a read on the same LSU stays pending.
  assign gnt_wr_s  = |(grant_s & lsu.W_request);
  assign gnt_rd_s  = |(grant_s & lsu.R_request & ~lsu.W_request);
  assign rd_word_s = mem[sel_addr_s];

  assign rr_next_s = (gnt_idx_s == PTR_W'(NUM_LSU - 1)) ? '0 : gnt_idx_s + PTR_W'(1);

  // Round-robin pointer: advances past the granted LSU, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (gnt_any_s) begin
      rr_ptr_r <= rr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Return registers: one-cycle rvalid pulse, rdata holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= '0;
      for (int i = 0; i < NUM_LSU; i++) begin
        rdata_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LSU; i++) begin
        rvalid_r[i] <= gnt_rd_s & grant_s[i];
        if (gnt_rd_s & grant_s[i]) begin
          rdata_r[i] <= rd_word_s;
        end else begin
          rdata_r[i] <= rdata_r[i];
        end
      end
    end
  end

  // Bank write port: preload first, then a granted LSU write. Not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_en) begin
        mem[init_addr] <= init_data;
      end else if (gnt_wr_s) begin
        mem[sel_addr_s] <= sel_wdata_s;
      end
    end
  end

  // Pack the per-LSU return slices as {rvalid, rdata}.
  always_comb begin
    lsu.CBG_to_LSU_bus = '0;
    for (int i = 0; i < NUM_LSU; i++) begin
      lsu.CBG_to_LSU_bus[i*(DATA_W+1) +: DATA_W+1] = {rvalid_r[i], rdata_r[i]};
    end
  end

  assign lsu.grant = grant_s;

endmodule

// File: tb/tb_cbg_bank_responder.sv
// ---------------------------------------------------------------------------
// tb_cbg_bank_responder
// Directed bench for cbg_bank_responder. Each step drives the inputs just
// after a rising edge, checks grant and every return slice mid-cycle, and
// updates a reference bank plus a queue of expected read returns.
// ---------------------------------------------------------------------------
module tb_cbg_bank_responder;

  localparam int NUM_LSU = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int SW      = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_en;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  cbg_bank_responder_if #(.NUM_LSU(NUM_LSU), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) lif ();

  cbg_bank_responder #(.NUM_LSU(NUM_LSU), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_en   (init_en),
    .init_addr (init_addr),
    .init_data (init_data),
    .lsu       (lif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                lsu;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t              sb [$];
  logic [DATA_W-1:0] model_mem [1 << ADDR_W];
  logic [DATA_W-1:0] last_rdata [NUM_LSU];
  int                total = 0;
  int                bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_lsu(input int i, input logic r, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    lif.R_request[i] = r;
    lif.W_request[i] = w;
    lif.LSU_addr_bus[i*ADDR_W +: ADDR_W]  = a;
    lif.LSU_wdata_bus[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_lsu(input int i);
    set_lsu(i, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock cycle: check outputs mid-cycle, predict effects, advance.
  task automatic step(input string tag, input logic [NUM_LSU-1:0] exp_grant);
    ret_t              e;
    logic [ADDR_W-1:0] a;
    #3;
    chk({tag, ":grant"}, 64'(lif.grant), 64'(exp_grant));
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.lsu  = -1;
      e.data = '0;
    end
    for (int i = 0; i < NUM_LSU; i++) begin
      if (e.lsu == i) last_rdata[i] = e.data;
      chk($sformatf("%s:slice%0d", tag, i),
          64'(lif.CBG_to_LSU_bus[i*SW +: SW]),
          64'({(e.lsu == i), last_rdata[i]}));
    end
    if (rst) begin
      sb.delete();
      for (int i = 0; i < NUM_LSU; i++) last_rdata[i] = '0;
    end else if (init_en) begin
      model_mem[init_addr] = init_data;
    end else begin
      for (int i = 0; i < NUM_LSU; i++) begin
        if (exp_grant[i]) begin
          a = lif.LSU_addr_bus[i*ADDR_W +: ADDR_W];
          if (lif.W_request[i]) model_mem[a] = lif.LSU_wdata_bus[i*DATA_W +: DATA_W];
          else if (lif.R_request[i]) sb.push_back('{lsu: i, data: model_mem[a]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    init_en   = 1'b1;
    init_addr = a;
    init_data = d;
    step(tag, 4'b0000);
    init_en   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    init_en   = 1'b0;
    init_addr = '0;
    init_data = '0;
    lif.R_request     = '0;
    lif.W_request     = '0;
    lif.LSU_addr_bus  = '0;
    lif.LSU_wdata_bus = '0;
    for (int i = 0; i < NUM_LSU; i++) last_rdata[i] = '0;
    @(posedge clk);
    #1;

    // Reset state
    step("reset", 4'b0000);
    rst = 1'b0;

    // Preload then single read by LSU0
    preload("t1_pre", 8'd5, 32'hDEADBEEF);
    set_lsu(0, 1'b1, 1'b0, 8'd5, 32'h0);
    step("t1_rd", 4'b0001);
    clear_lsu(0);
    step("t1_ret", 4'b0000);
    step("t1_idle", 4'b0000);

    // Round-robin from reset with all four LSUs reading
    rst = 1'b1;
    step("t2_rst", 4'b0000);
    rst = 1'b0;
    for (int k = 0; k < NUM_LSU; k++) begin
      preload("t2_pre", 8'(10 + k), 32'hC0DE_0000 + 32'(k));
    end
    for (int k = 0; k < NUM_LSU; k++) begin
      set_lsu(k, 1'b1, 1'b0, 8'(10 + k), 32'h0);
    end
    step("t2_g0", 4'b0001);
    step("t2_g1", 4'b0010);
    step("t2_g2", 4'b0100);
    step("t2_g3", 4'b1000);
    step("t2_g0b", 4'b0001);
    for (int k = 0; k < NUM_LSU; k++) clear_lsu(k);
    step("t2_tail", 4'b0000);
    step("t2_idle", 4'b0000);

    // Write then read by LSU2 (rr_ptr now 1)
    set_lsu(2, 1'b0, 1'b1, 8'h80, 32'h12345678);
    step("t3_wr", 4'b0100);
    set_lsu(2, 1'b1, 1'b0, 8'h80, 32'h0);
    step("t3_rd", 4'b0100);
    clear_lsu(2);
    step("t3_ret", 4'b0000);

    // Dual R+W from LSU1; LSU3 competes for the follow-up grant (rr_ptr 3)
    preload("t4_pre", 8'd3, 32'h00000011);
    set_lsu(1, 1'b1, 1'b1, 8'd3, 32'h000000A5);
    step("t4_wr", 4'b0010);
    set_lsu(1, 1'b1, 1'b0, 8'd3, 32'h0);
    set_lsu(3, 1'b1, 1'b0, 8'h80, 32'h0);
    step("t4_l3", 4'b1000);
    clear_lsu(3);
    step("t4_l1", 4'b0010);
    clear_lsu(1);
    step("t4_ret", 4'b0000);

    // Preload blocks LSU3 for three cycles (rr_ptr 2 held)
    set_lsu(3, 1'b1, 1'b0, 8'd5, 32'h0);
    for (int k = 0; k < 3; k++) begin
      preload("t5_blk", 8'(20 + k), 32'hB10C_0000 + 32'(k));
    end
    chk("t5_rr", 64'(dut.rr_ptr_r), 64'd2);
    step("t5_g3", 4'b1000);
    clear_lsu(3);
    step("t5_ret", 4'b0000);

    // Reset mid-operation drops the pending return
    set_lsu(0, 1'b1, 1'b0, 8'd5, 32'h0);
    step("t6_rd", 4'b0001);
    clear_lsu(0);
    rst = 1'b1;
    step("t6_rst", 4'b0000);
    rst = 1'b0;
    step("t6_after", 4'b0000);
    chk("t6_rr", 64'(dut.rr_ptr_r), 64'd0);
    set_lsu(0, 1'b1, 1'b0, 8'd5, 32'h0);
    step("t6_rd2", 4'b0001);
    clear_lsu(0);
    step("t6_ret", 4'b0000);
    step("t6_idle", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
